mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates one shared single-ported memory between the CPU's instruction-fetch port and data port. It serialises the two requesters onto one memory request/ready/rvalid channel and drives the program counter's stall input while any access is outstanding. A timeout watchdog returns an error response if the memory never answers. It sits between the core (fetch and load/store paths) and the unified memory.

## Interface
- ADDR_W, 32, address width for both requesters and memory.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before a forced error response; must be ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; sampled only in IDLE.
- if_addr  in  ADDR_W  fetch address.
- if_valid  out  1  one-cycle fetch response pulse.
- if_rdata  out  DATA_W  fetched word; valid with if_valid.
- d_req  in  1  data request; sampled only in IDLE.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle data response pulse.
- d_rdata  out  DATA_W  load data; valid with d_done; 0 for stores.
- resp_err  out  1  high with if_valid/d_done when the response is a timeout.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  latched write enable.
- mem_addr  out  ADDR_W  latched address; bits [1:0] forced to 0.
- mem_wdata  out  DATA_W  latched write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response/ack; required for reads and writes.
- mem_rdata  in  DATA_W  read data; valid with mem_rvalid.
- cpu_stall  out  1  connects to the program counter's stall input.

## Operation
- Four states:
  - IDLE: arbitrate.
  - ISSUE: mem_req=1.
  - WAIT: await mem_rvalid.
  - RESP: drive the response pulse.
- Arbitration in IDLE:
  - Only one requester pending: that requester is granted.
  - Both pending: the requester not served last wins (one-bit `last_grant` register; reset value = data, so fetch wins the first tie).
  - On grant, latch owner, we (0 for fetch), address and wdata, then go to ISSUE.
  - Requesters may drop req or change addr after the grant without effect.
- ISSUE: mem_req=1 with the latched fields. When mem_ready=1, go to WAIT.
- WAIT: when mem_rvalid=1, latch mem_rdata (0 for stores), go to RESP. mem_rvalid is ignored in any other state.
- RESP:
  - Pulse if_valid or d_done (owner only) for exactly one cycle, with registered rdata and resp_err.
  - Update last_grant to the owner.
  - Return to IDLE.
- Timeout:
  - Counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - When it reaches TIMEOUT: drop mem_req, go to RESP with rdata=0 and resp_err=1.
  - A late mem_rvalid after a timeout is ignored.
- cpu_stall = (if_req & ~if_valid) | (d_req & ~d_done). It is combinational and high in IDLE when any req is pending.
- Reset:
  - State→IDLE; all outputs 0 (mem_req, if_valid, d_done, resp_err, rdatas, mem_addr/we/wdata).
  - Counter→0; last_grant→data.
  - Reset mid-transaction abandons it with no response pulse.

## Timing
- Best case (mem_ready in the first ISSUE cycle, mem_rvalid in the first WAIT cycle):
  - req seen in IDLE at cycle N, ISSUE at N+1, WAIT at N+2, response pulse at N+3.
  - Latency 3 cycles; throughput one transaction per 4 cycles.
- Each extra cycle with mem_ready low, or mem_rvalid low, adds one cycle of latency.
- Requests are sampled only in IDLE. A req still high during RESP is seen as a new request in the following IDLE cycle.
- Timeout response appears exactly TIMEOUT+1 cycles after entering ISSUE (RESP entered after the counter hits TIMEOUT).
- At most one outstanding memory transaction; mem_req is never high outside ISSUE.

## Test plan
- Reset: rst=1 for 2 cycles with both reqs high → all outputs 0, no mem_req.
  - Release → fetch granted first (tie, last_grant=data).
- Single fetch, zero-wait memory: if_addr=0x0000_0013 → mem_addr=0x10, mem_we=0.
  - mem_rdata=0xDEADBEEF → if_valid pulse 3 cycles after req, if_rdata=0xDEADBEEF, cpu_stall low in that cycle.
- Contention: if_req and d_req held high continuously → grants alternate F,D,F,D.
  - Each response is exactly one cycle; store d_wdata=0x12345678 @0x100 appears on mem_wdata with mem_we=1.
- Wait states: mem_ready low 3 cycles, then mem_rvalid 2 cycles after accept → d_done 8 cycles after d_req.
  - mem_req stays high with stable fields through all 4 ISSUE cycles.
- Timeout with TIMEOUT=8: memory never asserts mem_ready → if_valid with resp_err=1 and if_rdata=0.
  - mem_req drops; a late mem_rvalid is ignored.
- Reset mid-WAIT → no response pulse, IDLE next cycle.
  - A subsequent mem_rvalid is ignored; a new request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data ports with round-robin tie-break.
// Latency 3 cycles best case; requesters are held off via cpu_stall, and a watchdog forces an error response.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic              owner_q;       // 1 = data port owns the transaction
    logic              last_grant_q;  // 1 = data port was served last
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_valid_q;
    logic              d_done_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              grant_data_d;
    logic [ADDR_W-1:0] grant_addr_d;
    logic              active_d;
    logic              timeout_d;
    logic              rsp_d;
    logic [DATA_W-1:0] rsp_data_d;

    assign grant_data_d = d_req & (~if_req | ~last_grant_q);
    assign grant_addr_d = grant_data_d ? d_addr : if_addr;
    assign active_d     = (state_q == ISSUE) || (state_q == WAIT);
    assign timeout_d    = active_d && (cnt_q == CNT_W'(TIMEOUT));
    assign rsp_d        = timeout_d || ((state_q == WAIT) && mem_rvalid);
    // Stores and timeouts return zero data.
    assign rsp_data_d   = (timeout_d || mem_we_q) ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_valid_q   <= 1'b0;
            d_done_q     <= 1'b0;
            resp_err_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_done_q   <= 1'b0;
            resp_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_q     <= grant_data_d;
                        mem_we_q    <= grant_data_d & d_we;
                        mem_addr_q  <= grant_addr_d & ~ADDR_W'(3);
                        mem_wdata_q <= grant_data_d ? d_wdata : '0;
                        mem_req_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (rsp_d) begin
                        mem_req_q  <= 1'b0;
                        resp_err_q <= timeout_d;
                        state_q    <= RESP;
                        if (owner_q) begin
                            d_done_q  <= 1'b1;
                            d_rdata_q <= rsp_data_d;
                        end else begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= rsp_data_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if ((state_q == ISSUE) && mem_ready) begin
                            mem_req_q <= 1'b0;
                            state_q   <= WAIT;
                        end
                    end
                end
                RESP: begin
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign resp_err  = resp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_stall = (if_req & ~if_valid_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the memory side is driven cycle by cycle from the main process.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_valid, d_done, resp_err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid, cpu_stall;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .cpu_stall(cpu_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int done_at;
        int req_cycles;
        logic exp_d;

        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 32'h0000_0013; d_addr = 32'h0000_0200; d_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset held two cycles with both requests high.
        step(); step();
        chk("rst_mem_bus", {mem_req, mem_we, mem_addr, mem_wdata}, 66'd0);
        chk("rst_resp", {if_valid, d_done, resp_err}, 3'b000);
        chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);

        // Release: tie goes to fetch, zero-wait memory.
        rst = 1'b0;
        chk("idle_stall", cpu_stall, 1'b1);
        step();
        chk("tie_fetch_issue", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0000_0010});
        d_req = 1'b0; if_addr = 32'hFFFF_FFF0; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("wait_req_low", mem_req, 1'b0);
        chk("addr_held", mem_addr, 32'h0000_0010);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        chk("fetch_pulse", {if_valid, d_done, resp_err}, 3'b100);
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("fetch_stall_low", cpu_stall, 1'b0);
        if_req = 1'b0;
        step();
        chk("fetch_one_cycle", {if_valid, d_done}, 2'b00);

        // Contention: fetch was served last, so data wins first, then alternate.
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 32'h0000_0040; d_addr = 32'h0000_0100; d_wdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            exp_d = (k % 2 == 0);
            step();
            chk($sformatf("cont%0d_issue", k), {mem_req, mem_we, mem_addr},
                {1'b1, exp_d, exp_d ? 32'h0000_0100 : 32'h0000_0040});
            chk($sformatf("cont%0d_wdata", k), mem_wdata, exp_d ? 32'h1234_5678 : 32'h0);
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + k;
            step();
            mem_rvalid = 1'b0;
            chk($sformatf("cont%0d_pulse", k), {if_valid, d_done}, {~exp_d, exp_d});
            if (exp_d) chk($sformatf("cont%0d_store_rdata", k), d_rdata, 32'h0);
            else       chk($sformatf("cont%0d_if_rdata", k), if_rdata, 32'hA0 + k);
            step();
            chk($sformatf("cont%0d_one_cycle", k), {if_valid, d_done}, 2'b00);
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

        // Wait states: three ready-low ISSUE cycles, two rvalid-low WAIT cycles.
        d_req = 1'b1; d_addr = 32'h0000_0204; d_wdata = 32'hFFFF_FFFF;
        done_at = 0;
        for (int t = 1; t <= 20 && done_at == 0; t++) begin
            step();
            if (t <= 4)
                chk($sformatf("ws_issue_t%0d", t), {mem_req, mem_we, mem_addr},
                    {1'b1, 1'b0, 32'h0000_0204});
            if (t == 5) chk("ws_stall", cpu_stall, 1'b1);
            if (d_done) done_at = t;
            mem_ready  = (t == 4);
            mem_rvalid = (t == 7);
            mem_rdata  = 32'hCAFE_F00D;
        end
        chk("ws_latency", done_at, 8);
        chk("ws_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        step();

        // Timeout: memory never accepts.
        if_req = 1'b1; if_addr = 32'h0000_0300;
        done_at = 0; req_cycles = 0;
        for (int t = 1; t <= 30 && done_at == 0; t++) begin
            step();
            if (mem_req) req_cycles++;
            if (if_valid) done_at = t;
        end
        chk("to_latency", done_at, 10);
        chk("to_req_cycles", req_cycles, 9);
        chk("to_resp", {if_valid, resp_err, mem_req}, 3'b110);
        chk("to_rdata", if_rdata, 32'h0);
        if_req = 1'b0;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        chk("to_late_rvalid", {if_valid, d_done, resp_err, mem_req}, 4'b0000);
        chk("to_rdata_kept", if_rdata, 32'h0);

        // Reset during WAIT abandons the store silently.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0044; d_wdata = 32'h0000_0055;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
        step();
        chk("midrst_outputs", {d_done, if_valid, mem_req, mem_addr}, 35'd0);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        step();
        mem_rvalid = 1'b0;
        chk("midrst_late_rvalid", {d_done, if_valid, mem_req}, 3'b000);
        if_req = 1'b1; if_addr = 32'h0000_0088;
        step();
        chk("post_rst_issue", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0000_0088});
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        step();
        mem_rvalid = 1'b0; if_req = 1'b0;
        chk("post_rst_resp", {if_valid, resp_err, if_rdata}, {1'b1, 1'b0, 32'h0000_1234});
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
